generation_sequencer: RTL and testbench

//   Parametrised successor to the Conway top-level controller. Sequences one

---
 rtl/conway_pkg.sv | 17 +
 rtl/delay_counter.sv | 35 +++
 rtl/generation_sequencer.sv | 139 +++++++++++++
 tb/tb_generation_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conway_pkg.sv
// Shared definitions for the life-generation sequencer: state encoding and default array width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conway_pkg;

  // Phases of one generation; WAIT is only reachable when the inter-generation delay is nonzero.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMPUTE,
    ST_STORE,
    ST_WAIT
  } state_t;

  localparam int DEFAULT_NUM_POS = 4;

endpackage

// File: rtl/delay_counter.sv
// Loadable down-counter that times the idle gap between generations.
// Latency: expired drops the cycle after load and rises again load_val cycles later.
// Backpressure: none; it free-runs down to zero and holds there.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset (clears the count)
//   load     in   reload the count with load_val on the next edge
//   load_val in   W-bit reload value
//   expired  out  count is zero
module delay_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/generation_sequencer.sv
// Sequences one life generation: load array, compute handshake, store back, optional idle gap.
// Latency: a start seen at edge k gives write_array=1, pos=0 right after edge k; period 2*NUM_POS+run+DELAY.
// Backpressure: the compute engine stalls the sequence by holding done low; step while busy is dropped.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   enable       in   free-run: start and keep starting generations while high
//   step         in   one-cycle pulse starting exactly one generation from IDLE
//   done         in   compute engine finished; only looked at in COMPUTE
//   write_array  out  array load strobe, one per position
//   run          out  compute request, held until done
//   pos          out  position index for load/store
//   write_mem    out  memory store strobe, one per position
//   busy         out  sequencer not idle
//   generation   out  completed-generation count (wraps)
module generation_sequencer
  import conway_pkg::*;
#(
  parameter  int NUM_POS = DEFAULT_NUM_POS,
  parameter  int DELAY   = 16,
  parameter  int GEN_W   = 16,
  localparam int POS_W   = $clog2(NUM_POS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             step,
  input  logic             done,
  output logic             write_array,
  output logic             run,
  output logic [POS_W-1:0] pos,
  output logic             write_mem,
  output logic             busy,
  output logic [GEN_W-1:0] generation
);

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(NUM_POS - 1);

  state_t           state;
  state_t           state_nxt;
  logic [POS_W-1:0] pos_nxt;
  logic             store_end;
  logic             wait_done;

  assign store_end = (state == ST_STORE) && (pos == LAST_POS);

  // The gap timer is reloaded on the last store cycle so that WAIT lasts exactly DELAY cycles.
  generate
    if (DELAY > 0) begin : g_wait
      localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;

      delay_counter #(
        .W(CNT_W)
      ) u_delay (
        .clk     (clk),
        .rst_n   (reset),
        .load    (store_end),
        .load_val(CNT_W'(DELAY - 1)),
        .expired (wait_done)
      );
    end else begin : g_no_wait
      assign wait_done = 1'b1;
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    case (state)
      ST_IDLE: begin
        if (enable || step) begin
          state_nxt = ST_LOAD;
          pos_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (pos == LAST_POS) begin
          state_nxt = ST_COMPUTE;
          pos_nxt   = '0;
        end else begin
          pos_nxt = pos + POS_W'(1);
        end
      end
      ST_COMPUTE: begin
        if (done) begin
          state_nxt = ST_STORE;
          pos_nxt   = '0;
        end
      end
      ST_STORE: begin
        if (store_end) begin
          pos_nxt = '0;
          if (DELAY > 0) begin
            state_nxt = ST_WAIT;
          end else begin
            state_nxt = enable ? ST_LOAD : ST_IDLE;
          end
        end else begin
          pos_nxt = pos + POS_W'(1);
        end
      end
      ST_WAIT: begin
        if (wait_done) begin
          state_nxt = enable ? ST_LOAD : ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        pos_nxt   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so each is a clean flop output
  // and at most one of them can be high in any cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pos         <= '0;
      generation  <= '0;
      write_array <= 1'b0;
      run         <= 1'b0;
      write_mem   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      pos         <= pos_nxt;
      write_array <= (state_nxt == ST_LOAD);
      run         <= (state_nxt == ST_COMPUTE);
      write_mem   <= (state_nxt == ST_STORE);
      busy        <= (state_nxt != ST_IDLE);
      if (store_end) begin
        generation <= generation + GEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_generation_sequencer.sv
// Directed bench for generation_sequencer: default instance plus a DELAY=0, GEN_W=4 instance.
// Latency: n/a.
// Backpressure: done is raised on the third run cycle of the default instance; tied high on the other.
module tb_generation_sequencer;

  localparam int DONE_AT = 3;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        step;
  logic        done;
  logic        write_array;
  logic        run;
  logic [1:0]  pos;
  logic        write_mem;
  logic        busy;
  logic [15:0] generation;

  logic        reset2;
  logic        enable2;
  logic        step2;
  logic        done2;
  logic        write_array2;
  logic        run2;
  logic [1:0]  pos2;
  logic        write_mem2;
  logic        busy2;
  logic [3:0]  generation2;

  int checks;
  int errors;
  int run_cnt;

  generation_sequencer #(
    .NUM_POS(4),
    .DELAY  (16),
    .GEN_W  (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .step       (step),
    .done       (done),
    .write_array(write_array),
    .run        (run),
    .pos        (pos),
    .write_mem  (write_mem),
    .busy       (busy),
    .generation (generation)
  );

  generation_sequencer #(
    .NUM_POS(4),
    .DELAY  (0),
    .GEN_W  (4)
  ) dut2 (
    .clk        (clk),
    .reset      (reset2),
    .enable     (enable2),
    .step       (step2),
    .done       (done2),
    .write_array(write_array2),
    .run        (run2),
    .pos        (pos2),
    .write_mem  (write_mem2),
    .busy       (busy2),
    .generation (generation2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compute engine model: finishes on the DONE_AT-th consecutive run cycle.
  initial begin
    done    = 1'b0;
    run_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (run) begin
        run_cnt = run_cnt + 1;
        done    = (run_cnt == DONE_AT);
      end else begin
        run_cnt = 0;
        done    = 1'b0;
      end
    end
  end

  function automatic logic [31:0] obs1();
    return {10'b0, write_array, run, write_mem, busy, pos, generation};
  endfunction

  function automatic logic [31:0] e1(input logic wa, input logic rn, input logic wm,
                                     input logic bz, input int p, input logic [15:0] g);
    logic [1:0] pp;
    pp = p[1:0];
    return {10'b0, wa, rn, wm, bz, pp, g};
  endfunction

  function automatic logic [31:0] obs2();
    return {22'b0, write_array2, run2, write_mem2, busy2, pos2, generation2};
  endfunction

  function automatic logic [31:0] e2(input logic wa, input logic rn, input logic wm,
                                     input logic bz, input int p, input logic [3:0] g);
    logic [1:0] pp;
    pp = p[1:0];
    return {22'b0, wa, rn, wm, bz, pp, g};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks one full generation of the default instance, starting at LOAD pos 0.
  task automatic run_gen(input logic [15:0] g, input int rc);
    for (int i = 0; i < 4; i++) begin
      chk("load", obs1(), e1(1, 0, 0, 1, i, g));
      tick();
    end
    for (int i = 0; i < rc; i++) begin
      chk("compute", obs1(), e1(0, 1, 0, 1, 0, g));
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      chk("store", obs1(), e1(0, 0, 1, 1, i, g));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      chk("wait", obs1(), e1(0, 0, 0, 1, 0, g + 16'd1));
      tick();
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    enable  = 1'b0;
    step    = 1'b0;
    reset2  = 1'b0;
    enable2 = 1'b0;
    step2   = 1'b0;
    done2   = 1'b1;

    // 1: reset held, then released with no controls.
    #2;
    chk("reset_hold", obs1(), e1(0, 0, 0, 0, 0, 16'd0));
    repeat (3) tick();
    chk("reset_hold_clocked", obs1(), e1(0, 0, 0, 0, 0, 16'd0));
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_after_reset", obs1(), e1(0, 0, 0, 0, 0, 16'd0));
    end

    // 2: single step.
    step = 1'b1;
    tick();
    step = 1'b0;
    run_gen(16'd0, 3);
    chk("step_back_to_idle", obs1(), e1(0, 0, 0, 0, 0, 16'd1));
    tick();
    chk("step_stays_idle", obs1(), e1(0, 0, 0, 0, 0, 16'd1));

    // 3: free-run from a fresh reset; generations follow with no extra gap.
    reset = 1'b0;
    #1;
    chk("reset_between_tests", obs1(), e1(0, 0, 0, 0, 0, 16'd0));
    reset  = 1'b1;
    enable = 1'b1;
    tick();
    run_gen(16'd0, 3);
    run_gen(16'd1, 3);
    run_gen(16'd2, 3);

    // 4: enable dropped during COMPUTE; step pulses while busy are ignored.
    for (int i = 0; i < 4; i++) begin
      chk("drop_load", obs1(), e1(1, 0, 0, 1, i, 16'd3));
      tick();
    end
    enable = 1'b0;
    step   = 1'b1;
    chk("drop_compute1", obs1(), e1(0, 1, 0, 1, 0, 16'd3));
    tick();
    step = 1'b0;
    chk("drop_compute2", obs1(), e1(0, 1, 0, 1, 0, 16'd3));
    tick();
    chk("drop_compute3", obs1(), e1(0, 1, 0, 1, 0, 16'd3));
    tick();
    for (int i = 0; i < 4; i++) begin
      step = (i == 1);
      chk("drop_store", obs1(), e1(0, 0, 1, 1, i, 16'd3));
      tick();
    end
    step = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step = (i == 15);
      chk("drop_wait", obs1(), e1(0, 0, 0, 1, 0, 16'd4));
      tick();
    end
    step = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("drop_idle", obs1(), e1(0, 0, 0, 0, 0, 16'd4));
      tick();
    end

    // 5: asynchronous reset in the middle of STORE.
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    chk("store_pos0_before_reset", obs1(), e1(0, 0, 1, 1, 0, 16'd4));
    tick();
    tick();
    chk("store_pos2_before_reset", obs1(), e1(0, 0, 1, 1, 2, 16'd4));
    #2;
    reset = 1'b0;
    #1;
    chk("async_reset_mid_store", obs1(), e1(0, 0, 0, 0, 0, 16'd0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    chk("idle_after_async_reset", obs1(), e1(0, 0, 0, 0, 0, 16'd0));
    step = 1'b1;
    tick();
    step = 1'b0;
    run_gen(16'd0, 3);
    chk("restart_idle", obs1(), e1(0, 0, 0, 0, 0, 16'd1));

    // 6: no WAIT state, 4-bit counter wraps after 16 generations; done held high.
    chk("nowait_reset", obs2(), e2(0, 0, 0, 0, 0, 4'd0));
    reset2  = 1'b1;
    enable2 = 1'b1;
    tick();
    for (int g = 0; g < 16; g++) begin
      for (int i = 0; i < 4; i++) begin
        chk("nowait_load", obs2(), e2(1, 0, 0, 1, i, 4'(g)));
        tick();
      end
      chk("nowait_compute", obs2(), e2(0, 1, 0, 1, 0, 4'(g)));
      tick();
      for (int i = 0; i < 4; i++) begin
        chk("nowait_store", obs2(), e2(0, 0, 1, 1, i, 4'(g)));
        tick();
      end
    end
    chk("nowait_wrap", obs2(), e2(1, 0, 0, 1, 0, 4'd0));
    enable2 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
